// File: rtl/data_mem_responder_if.sv
// rtl/data_mem_responder_if.sv - request/response channel bundle for the data-memory responder
interface data_mem_responder_if;
  logic        i_ReqValid;
  logic        o_ReqReady;
  logic        i_ReqWrite;
  logic [31:0] i_ReqAddr;
  logic [31:0] i_ReqWData;
  logic [3:0]  i_ReqByteEn;
  logic        o_RspValid;
  logic        i_RspReady;
  logic [31:0] o_RspRData;
  logic        o_RspErr;
  logic        o_Busy;

  modport master (
    output i_ReqValid, i_ReqWrite, i_ReqAddr, i_ReqWData, i_ReqByteEn, i_RspReady,
    input  o_ReqReady, o_RspValid, o_RspRData, o_RspErr, o_Busy
  );

  modport slave (
    input  i_ReqValid, i_ReqWrite, i_ReqAddr, i_ReqWData, i_ReqByteEn, i_RspReady,
    output o_ReqReady, o_RspValid, o_RspRData, o_RspErr, o_Busy
  );
endinterface

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - load/store data-memory target with programmable wait states
// Optional DMEM_ALIGN_CHECK_EN adds misalignment faults on top of range faults.
module data_mem_responder #(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 2
) (
  input logic                 i_Clk,
  input logic                 i_Reset,
  data_mem_responder_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;
  localparam int DEPTH = 2 ** ADDR_W;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic        write_q, write_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic [31:0] mem_q [DEPTH];

  logic              accept;
  logic              commit;
  logic [31:0]       c_addr;
  logic [31:0]       c_wdata;
  logic [3:0]        c_be;
  logic              c_write;
  logic              range_fault;
  logic              align_fault;
  logic              c_fault;
  logic [ADDR_W-1:0] idx;

  assign accept = (state_q == S_IDLE) && bus.i_ReqValid;
  // Zero-wait accesses commit on the accept edge, straight from the request bus.
  assign commit  = (accept && (WAIT_CYCLES == 0)) || ((state_q == S_WAIT) && (cnt_q == 4'd1));
  assign c_addr  = (state_q == S_IDLE) ? bus.i_ReqAddr    : addr_q;
  assign c_wdata = (state_q == S_IDLE) ? bus.i_ReqWData   : wdata_q;
  assign c_be    = (state_q == S_IDLE) ? bus.i_ReqByteEn  : be_q;
  assign c_write = (state_q == S_IDLE) ? bus.i_ReqWrite   : write_q;

  assign idx         = c_addr[ADDR_W+1:2];
  assign range_fault = (c_addr >> (ADDR_W + 2)) != 32'd0;

`ifdef DMEM_ALIGN_CHECK_EN
  logic single_lane;
  assign single_lane = (c_be == 4'b0001) || (c_be == 4'b0010) ||
                       (c_be == 4'b0100) || (c_be == 4'b1000);
  assign align_fault = (c_addr[1:0] != 2'd0) &&
                       (!c_write || !(single_lane || ((c_be == 4'b1100) && (c_addr[1:0] == 2'd2))));
`else
  assign align_fault = 1'b0;
`endif

  assign c_fault = range_fault || align_fault;

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      be_q    <= 4'd0;
      write_q <= 1'b0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      write_q <= write_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    write_d = write_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (bus.i_ReqValid) begin
          addr_d  = bus.i_ReqAddr;
          wdata_d = bus.i_ReqWData;
          be_d    = bus.i_ReqByteEn;
          write_d = bus.i_ReqWrite;
          cnt_d   = 4'(WAIT_CYCLES);
          state_d = (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (bus.i_RspReady) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (commit) begin
      rdata_d = (!c_write && !c_fault) ? mem_q[idx] : 32'd0;
      err_d   = c_fault;
    end
  end

  // Storage is deliberately left out of reset; reset only gates the write strobe.
  always_ff @(posedge i_Clk) begin
    if (commit && c_write && !c_fault && !i_Reset) begin
      for (int k = 0; k < 4; k++) begin
        if (c_be[k]) begin
          mem_q[idx][8*k +: 8] <= c_wdata[8*k +: 8];
        end
      end
    end
  end

  assign bus.o_ReqReady = (state_q == S_IDLE);
  assign bus.o_RspValid = (state_q == S_RESP);
  assign bus.o_Busy     = (state_q != S_IDLE);
  assign bus.o_RspRData = rdata_q;
  assign bus.o_RspErr   = err_q;
endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - randomized bench with transaction-level reference model
// Instance 0 runs WAIT_CYCLES=2, instance 1 runs WAIT_CYCLES=0.
module tb_data_mem_responder;
  localparam int AW = 10;
  localparam int WC [2] = '{2, 0};

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        req_valid [2];
  logic        req_write [2];
  logic [31:0] req_addr  [2];
  logic [31:0] req_wdata [2];
  logic [3:0]  req_be    [2];
  logic        rsp_ready [2];
  logic        rq_ready  [2];
  logic        rs_valid  [2];
  logic [31:0] rs_rdata  [2];
  logic        rs_err    [2];
  logic        rs_busy   [2];

  data_mem_responder_if bus0 ();
  data_mem_responder_if bus1 ();

  assign bus0.i_ReqValid  = req_valid[0];
  assign bus0.i_ReqWrite  = req_write[0];
  assign bus0.i_ReqAddr   = req_addr[0];
  assign bus0.i_ReqWData  = req_wdata[0];
  assign bus0.i_ReqByteEn = req_be[0];
  assign bus0.i_RspReady  = rsp_ready[0];
  assign rq_ready[0] = bus0.o_ReqReady;
  assign rs_valid[0] = bus0.o_RspValid;
  assign rs_rdata[0] = bus0.o_RspRData;
  assign rs_err[0]   = bus0.o_RspErr;
  assign rs_busy[0]  = bus0.o_Busy;

  assign bus1.i_ReqValid  = req_valid[1];
  assign bus1.i_ReqWrite  = req_write[1];
  assign bus1.i_ReqAddr   = req_addr[1];
  assign bus1.i_ReqWData  = req_wdata[1];
  assign bus1.i_ReqByteEn = req_be[1];
  assign bus1.i_RspReady  = rsp_ready[1];
  assign rq_ready[1] = bus1.o_ReqReady;
  assign rs_valid[1] = bus1.o_RspValid;
  assign rs_rdata[1] = bus1.o_RspRData;
  assign rs_err[1]   = bus1.o_RspErr;
  assign rs_busy[1]  = bus1.o_Busy;

  data_mem_responder #(.ADDR_W(AW), .WAIT_CYCLES(2)) dut0 (.i_Clk(clk), .i_Reset(rst), .bus(bus0));
  data_mem_responder #(.ADDR_W(AW), .WAIT_CYCLES(0)) dut1 (.i_Clk(clk), .i_Reset(rst), .bus(bus1));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: one outstanding transaction per instance, tracked by edge numbers.
  logic [31:0] m_mem [2][1024];
  bit          m_out [2];
  int          m_ea  [2];
  logic        m_wr  [2];
  logic [31:0] m_addr[2];
  logic [31:0] m_wd  [2];
  logic [3:0]  m_be  [2];
  logic [31:0] m_rd  [2];
  logic        m_err [2];
  int          m_e;
  bit          m_done;

  function automatic bit exp_fault(input logic wr, input logic [31:0] a, input logic [3:0] be);
    bit f;
    f = (a >= (32'd1 << (AW + 2)));
`ifdef DMEM_ALIGN_CHECK_EN
    if ((a[1:0] != 2'd0) && (!wr || !(($countones(be) == 1) || ((be == 4'hC) && (a[1:0] == 2'd2)))))
      f = 1'b1;
`endif
    return f;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int d = 0; d < 2; d++) m_out[d] = 1'b0;
    end else begin
      m_e = cyc + 1;
      for (int d = 0; d < 2; d++) begin
        m_done = 1'b0;
        if (m_out[d] && (m_e - 1 >= m_ea[d] + WC[d]) && rsp_ready[d]) begin
          m_out[d] = 1'b0;
          m_done   = 1'b1;
        end
        if (!m_out[d] && !m_done && req_valid[d]) begin
          m_out[d]  = 1'b1;
          m_ea[d]   = m_e;
          m_wr[d]   = req_write[d];
          m_addr[d] = req_addr[d];
          m_wd[d]   = req_wdata[d];
          m_be[d]   = req_be[d];
        end
        if (m_out[d] && (m_e == m_ea[d] + WC[d])) begin
          m_err[d] = exp_fault(m_wr[d], m_addr[d], m_be[d]);
          if (m_wr[d] && !m_err[d])
            for (int k = 0; k < 4; k++)
              if (m_be[d][k]) m_mem[d][m_addr[d][11:2]][8*k +: 8] = m_wd[d][8*k +: 8];
          m_rd[d] = (!m_wr[d] && !m_err[d]) ? m_mem[d][m_addr[d][11:2]] : 32'd0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      for (int d = 0; d < 2; d++) begin
        check($sformatf("i%0d_req_ready", d), 32'(rq_ready[d]), 32'(!m_out[d]));
        check($sformatf("i%0d_busy", d), 32'(rs_busy[d]), 32'(m_out[d]));
        check($sformatf("i%0d_rsp_valid", d), 32'(rs_valid[d]), 32'(m_out[d] && (cyc >= m_ea[d] + WC[d])));
        if (m_out[d] && (cyc >= m_ea[d] + WC[d])) begin
          check($sformatf("i%0d_rdata", d), rs_rdata[d], m_rd[d]);
          check($sformatf("i%0d_err", d), 32'(rs_err[d]), 32'(m_err[d]));
        end
      end
    end
  end

  task automatic txn(input int d, input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                     input logic [3:0] be, input int stall, input bit early,
                     output logic [31:0] rd, output logic er, output int lat);
    int n;
    @(negedge clk);
    req_valid[d] = 1'b1; req_write[d] = wr; req_addr[d] = addr;
    req_wdata[d] = wd;   req_be[d] = be;    rsp_ready[d] = 1'b0;
    n = 0;
    while (!rq_ready[d] && n < 50) begin @(negedge clk); n++; end
    check("accept_timeout", 32'(n < 50), 32'd1);
    @(posedge clk); #1;
    req_valid[d] = 1'b0;
    req_write[d] = 1'($urandom); req_addr[d] = $urandom;
    req_wdata[d] = $urandom;     req_be[d] = 4'($urandom);
    if (early) rsp_ready[d] = 1'b1;
    lat = 0;
    while (!rs_valid[d] && lat < 50) begin @(posedge clk); #1; lat++; end
    check("response_timeout", 32'(lat < 50), 32'd1);
    rd = rs_rdata[d];
    er = rs_err[d];
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check("hold_valid", 32'(rs_valid[d]), 32'd1);
      check("hold_rdata", rs_rdata[d], rd);
      check("hold_busy", 32'(rs_busy[d]), 32'd1);
      check("hold_ready", 32'(rq_ready[d]), 32'd0);
    end
    @(negedge clk);
    rsp_ready[d] = 1'b1;
    @(posedge clk); #1;
    check("done_valid", 32'(rs_valid[d]), 32'd0);
    check("done_ready", 32'(rq_ready[d]), 32'd1);
    rsp_ready[d] = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;
    logic [31:0] a;
    for (int d = 0; d < 2; d++) begin
      req_valid[d] = 1'b0; req_write[d] = 1'b0; req_addr[d] = 32'd0;
      req_wdata[d] = 32'd0; req_be[d] = 4'd0; rsp_ready[d] = 1'b0;
    end
    #1;
    for (int d = 0; d < 2; d++) begin
      check("reset_req_ready", 32'(rq_ready[d]), 32'd1);
      check("reset_rsp_valid", 32'(rs_valid[d]), 32'd0);
      check("reset_rdata", rs_rdata[d], 32'd0);
      check("reset_err", 32'(rs_err[d]), 32'd0);
      check("reset_busy", 32'(rs_busy[d]), 32'd0);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Preload the test window of both instances with known words.
    for (int d = 0; d < 2; d++) begin
      for (int w = 0; w < 64; w++) begin
        case (w)
          0:       a = 32'hCAFEF00D;
          8:       a = 32'h11223344;
          12:      a = 32'h00000000;
          default: a = $urandom;
        endcase
        txn(d, 1'b1, 32'(w * 4), a, 4'hF, 0, 1'b0, rd, er, lat);
      end
    end

    txn(0, 1'b1, 32'h010, 32'hDEADBEEF, 4'hF, 0, 1'b0, rd, er, lat);
    check("store_cycles_after_accept", 32'(lat + 1), 32'd3);
    check("store_err", 32'(er), 32'd0);
    check("store_rdata", rd, 32'd0);
    txn(0, 1'b0, 32'h010, 32'h0, 4'h0, 0, 1'b0, rd, er, lat);
    check("load_deadbeef", rd, 32'hDEADBEEF);

    txn(0, 1'b1, 32'h020, 32'h0000AA00, 4'b0010, 0, 1'b0, rd, er, lat);
    txn(0, 1'b0, 32'h020, 32'h0, 4'h0, 0, 1'b0, rd, er, lat);
    check("byte_lane_merge", rd, 32'h1122AA44);

    txn(0, 1'b0, 32'h010, 32'h0, 4'h0, 5, 1'b0, rd, er, lat);
    check("backpressure_rdata", rd, 32'hDEADBEEF);

    txn(0, 1'b1, 32'h1000, 32'h12345678, 4'hF, 0, 1'b0, rd, er, lat);
    check("range_fault_err", 32'(er), 32'd1);
    txn(0, 1'b0, 32'h000, 32'h0, 4'h0, 0, 1'b0, rd, er, lat);
    check("range_fault_no_write", rd, 32'hCAFEF00D);
    check("range_fault_load_err", 32'(er), 32'd0);

    // Reset during WAIT aborts the store.
    @(negedge clk);
    req_valid[0] = 1'b1; req_write[0] = 1'b1; req_addr[0] = 32'h030;
    req_wdata[0] = 32'h55; req_be[0] = 4'hF;
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("abort_req_ready", 32'(rq_ready[0]), 32'd1);
    check("abort_rsp_valid", 32'(rs_valid[0]), 32'd0);
    check("abort_busy", 32'(rs_busy[0]), 32'd0);
    check("abort_rdata", rs_rdata[0], 32'd0);
    check("abort_err", 32'(rs_err[0]), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    txn(0, 1'b0, 32'h030, 32'h0, 4'h0, 0, 1'b0, rd, er, lat);
    check("abort_no_write", rd, 32'h00000000);

    // Reset during RESP drops the response but the write stays.
    @(negedge clk);
    req_valid[0] = 1'b1; req_write[0] = 1'b1; req_addr[0] = 32'h034;
    req_wdata[0] = 32'h77; req_be[0] = 4'hF;
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("resp_reached", 32'(rs_valid[0]), 32'd1);
    rst = 1'b1;
    #1;
    check("resp_reset_valid", 32'(rs_valid[0]), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    txn(0, 1'b0, 32'h034, 32'h0, 4'h0, 0, 1'b0, rd, er, lat);
    check("resp_reset_write_kept", rd, 32'h00000077);

`ifdef DMEM_ALIGN_CHECK_EN
    txn(0, 1'b0, 32'h032, 32'h0, 4'h0, 0, 1'b0, rd, er, lat);
    check("misaligned_load_err", 32'(er), 32'd1);
    check("misaligned_load_rdata", rd, 32'd0);
`endif

    // Zero-wait back-to-back loads: accepts alternate with responses.
    @(negedge clk);
    req_valid[1] = 1'b1; req_write[1] = 1'b0; req_addr[1] = 32'h000; rsp_ready[1] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("b2b_req_ready", 32'(rq_ready[1]), 32'((i % 2) == 0));
      check("b2b_rsp_valid", 32'(rs_valid[1]), 32'((i % 2) == 1));
      if ((i % 2) == 1) check("b2b_rdata", rs_rdata[1], 32'hCAFEF00D);
      @(negedge clk);
    end
    req_valid[1] = 1'b0; rsp_ready[1] = 1'b0;
    txn(1, 1'b0, 32'h020, 32'h0, 4'h0, 0, 1'b0, rd, er, lat);
    check("w0_latency", 32'(lat + 1), 32'd1);
    check("w0_load_preload", rd, 32'h11223344);

    for (int d = 0; d < 2; d++) begin
      for (int t = 0; t < 80; t++) begin
        int st;
        a = 32'($urandom_range(0, 255));
        if ($urandom_range(0, 9) == 0) a = a | (32'd1 << $urandom_range(AW + 2, 31));
        st = $urandom_range(0, 3);
        txn(d, 1'($urandom), a, $urandom, 4'($urandom), st, (st == 0) && ($urandom_range(0, 1) == 1),
            rd, er, lat);
        check("rand_latency", 32'(lat), 32'(WC[d]));
      end
    end

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
